// File: rtl/des_round_ctrl.sv
// Iterative DES engine: one Feistel round per clock, one block in flight, valid/ready on both sides.
// Optional build macro DES_DECRYPT_EN adds the in_decrypt port and the reverse key schedule.

module des_f_block (
  input  logic [47:0] key_i,
  input  logic [31:0] half_i,
  output logic [31:0] f_o
);

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Flattened S1..S8, 64 entries each, row-major (row = b1b6, column = b2..b5).
  localparam bit [3:0] SBOX [512] = '{
    14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
     0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
     4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
    15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
    15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
     3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
     0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
    13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
    10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
    13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
    13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
     1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
     7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
    13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
    10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
     3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
     2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
    14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
     4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
    11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
    12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
    10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
     9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
     4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
     4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
    13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
     1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
     6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
    13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
     1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
     7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
     2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

  logic [47:0] x;
  logic [31:0] s_out;
  logic [5:0]  chunk;

  always_comb begin
    x     = '0;
    s_out = '0;
    chunk = '0;
    f_o   = '0;
    for (int j = 1; j <= 48; j++) x[48-j] = half_i[32-E_T[j-1]];
    x = x ^ key_i;
    for (int b = 0; b < 8; b++) begin
      chunk = x[47-6*b -: 6];
      s_out[31-4*b -: 4] = SBOX[b*64 + int'({chunk[5], chunk[0]})*16 + int'(chunk[4:1])];
    end
    for (int j = 1; j <= 32; j++) f_o[32-j] = s_out[32-P_T[j-1]];
  end

endmodule

module des_round_ctrl #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
`ifdef DES_DECRYPT_EN
  input  logic        in_decrypt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 1; j <= 64; j++) y[64-j] = x[64-IP_T[j-1]];
    return y;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 1; j <= 64; j++) y[64-j] = x[64-FP_T[j-1]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] y;
    y = '0;
    for (int j = 1; j <= 56; j++) y[56-j] = x[64-PC1_T[j-1]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] y;
    y = '0;
    for (int j = 1; j <= 48; j++) y[48-j] = x[56-PC2_T[j-1]];
    return y;
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; all others by two.
  function automatic logic dbl_shift_f(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  round_cnt_q, round_cnt_d;
  logic [31:0] l_q, l_d, r_q, r_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [63:0] out_data_q, out_data_d;
  logic        mode_q;

  logic [27:0] c_rotl, d_rotl, c_next, d_next;
  logic [47:0] round_key;
  logic [31:0] f_out, l_new, r_new;
  logic [63:0] ip_in;
  logic [55:0] pc1_in;
  logic        unused_key_parity;

  assign unused_key_parity = ^{in_key[56], in_key[48], in_key[40], in_key[32],
                               in_key[24], in_key[16], in_key[8], in_key[0]};

  assign c_rotl = dbl_shift_f(round_cnt_q) ? {c_q[25:0], c_q[27:26]} : {c_q[26:0], c_q[27]};
  assign d_rotl = dbl_shift_f(round_cnt_q) ? {d_q[25:0], d_q[27:26]} : {d_q[26:0], d_q[27]};

`ifdef DES_DECRYPT_EN
  logic        mode_d;
  logic [3:0]  dec_idx;
  logic [27:0] c_rotr, d_rotr;

  // Decrypt walks the schedule backwards: use the current C||D, then undo shift s[17-i].
  assign dec_idx = 4'd15 - round_cnt_q;
  assign c_rotr  = dbl_shift_f(dec_idx) ? {c_q[1:0], c_q[27:2]} : {c_q[0], c_q[27:1]};
  assign d_rotr  = dbl_shift_f(dec_idx) ? {d_q[1:0], d_q[27:2]} : {d_q[0], d_q[27:1]};

  always_comb begin
    if (mode_q) begin
      round_key = pc2_f({c_q, d_q});
      c_next    = c_rotr;
      d_next    = d_rotr;
    end else begin
      round_key = pc2_f({c_rotl, d_rotl});
      c_next    = c_rotl;
      d_next    = d_rotl;
    end
  end

  assign mode_d = (state_q == IDLE && in_valid) ? in_decrypt : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end
`else
  assign mode_q    = 1'b0;
  assign round_key = pc2_f({c_rotl, d_rotl});
  assign c_next    = c_rotl;
  assign d_next    = d_rotl;
`endif

  des_f_block u_f_block (
    .key_i  (round_key),
    .half_i (r_q),
    .f_o    (f_out)
  );

  assign l_new  = r_q;
  assign r_new  = l_q ^ f_out;
  assign ip_in  = ip_f(in_data);
  assign pc1_in = pc1_f(in_key);

  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    l_d         = l_q;
    r_d         = r_q;
    c_d         = c_q;
    d_d         = d_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = ROUND;
          round_cnt_d = 4'd0;
          {l_d, r_d}  = ip_in;
          {c_d, d_d}  = pc1_in;
        end
      end
      ROUND: begin
        l_d = l_new;
        r_d = r_new;
        c_d = c_next;
        d_d = d_next;
        if (round_cnt_q == LAST_RND) begin
          state_d    = DONE;
          out_data_d = fp_f({r_new, l_new});
        end else begin
          round_cnt_d = round_cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_cnt_q <= 4'd0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      l_q         <= l_d;
      r_q         <= r_d;
      c_q         <= c_d;
      d_q         <= d_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == ROUND) || (state_q == DONE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Scoreboard bench for des_round_ctrl using published DES known-answer vectors.
// Define DES_DECRYPT_EN for both bench and RTL to include the decrypt vector.

module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic [63:0] in_key = '0;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_data;
`ifdef DES_DECRYPT_EN
  logic        in_decrypt = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  des_round_ctrl #(.NUM_ROUNDS(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_key     (in_key),
`ifdef DES_DECRYPT_EN
    .in_decrypt (in_decrypt),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offers one block and returns 1 time unit after the accepting edge.
  task automatic drive_block(input logic [63:0] d, input logic [63:0] k, input logic [63:0] exp);
    int waitc = 0;
    in_data  = d;
    in_key   = k;
    in_valid = 1'b1;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back(exp);
    #1;
    in_valid = 1'b0;
    chk("accept_busy", 64'(busy), 64'd1);
    chk("accept_rdy", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_out(input string tag, input bit noise, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (noise) begin
        chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom};
        in_key   = {$urandom, $urandom};
      end
    end
    in_valid = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), 64'd16);
  endtask

  task automatic pop_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, out_data, e);
    end
  endtask

  task automatic collect(input string tag, input int hold, input bit noise);
    int          cyc;
    logic [63:0] held;
    out_ready = 1'b0;
    wait_out(tag, noise, cyc);
    if (!out_valid) return;
    held = out_data;
    pop_check(tag);
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_data"}, out_data, held);
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ovld_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int stale;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_ovld", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", out_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    collect("t1", 0, 1'b0);
    drive_block(64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7);
    collect("t2", 0, 1'b0);
    drive_block(64'h8787878787878787, 64'h0E329232EA6D0D73, 64'h0000000000000000);
    collect("kat_zero_ct", 0, 1'b0);
    drive_block(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58);
    collect("kat_ones", 0, 1'b0);
    drive_block(64'h4E6F772069732074, 64'h0123456789ABCDEF, 64'h3FA40E8A984D4815);
    collect("kat_nowis", 0, 1'b0);

    drive_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    collect("t4", 10, 1'b0);

    drive_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    collect("t5", 0, 1'b1);

    // in_valid and out_ready together in DONE: only the consume acts.
    drive_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    wait_out("both", 1'b0, cyc);
    pop_check("both_a");
    in_data   = 64'h0;
    in_key    = 64'h0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("both_idle_rdy", 64'(in_ready), 64'd1);
    chk("both_idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    exp_q.push_back(64'h8CA64DE9C1B123A7);
    #1;
    in_valid = 1'b0;
    chk("both_next_busy", 64'(busy), 64'd1);
    collect("both_b", 0, 1'b0);

    drive_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rdy", 64'(in_ready), 64'd1);
    chk("t6_ovld", 64'(out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_data", out_data, 64'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    chk("t6_stale", 64'(stale), 64'd0);
    @(negedge clk);
    drive_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    collect("t6_rerun", 0, 1'b0);

`ifdef DES_DECRYPT_EN
    in_decrypt = 1'b1;
    drive_block(64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF);
    collect("t3_dec", 0, 1'b0);
    in_decrypt = 1'b0;
    drive_block(64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    collect("t3_enc_after", 0, 1'b0);
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
